// File: rtl/result_pack_pkg.sv
// Shared constants and types for the result packer: config address map,
// serializer state encoding and a small frame-length helper.
package result_pack_pkg;

  localparam int CFG_RESULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // A programmed frame length of zero behaves as one result per frame.
  function automatic logic [15:0] eff_frame(input logic [15:0] nb);
    return (nb == 16'd0) ? 16'd1 : nb;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO, parameterized width and depth, async active-high reset.
// A push while full is dropped even if a pop happens in the same cycle.
module result_fifo #(
  parameter int W  = 64,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_pack.sv
// Buffers full-width layer results and serializes them LSB-word first onto a
// valid/ready stream, flagging the last word of each configured frame.
module result_pack
  import result_pack_pkg::*;
#(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int DEPTH_NB   = 16,
  parameter int IMG_WIDTH  = 16,
  parameter int STR_WIDTH  = 64,
  parameter int FIFO_AW    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [DEPTH_NB*IMG_WIDTH-1:0] result_bus,
  input  logic                          result_val,
  output logic                          result_rdy,
  output logic [STR_WIDTH-1:0]          str_data,
  output logic                          str_last,
  output logic                          str_val,
  input  logic                          str_rdy
);

  localparam int RW    = DEPTH_NB * IMG_WIDTH;
  localparam int WORDS = RW / STR_WIDTH;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCW-1:0] LAST_W = WCW'(WORDS - 1);

  state_t               state, state_n;
  logic [RW-1:0]        sreg, sreg_n;
  logic [STR_WIDTH-1:0] data_n;
  logic                 val_n, last_n;
  logic [WCW-1:0]       wcnt, wcnt_n;
  logic [15:0]          res_cnt, res_n, frame_nb, fn_eff;
  logic                 cfg_wr, frame_end, pop;
  logic                 fifo_full, fifo_empty;
  logic [FIFO_AW:0]     fifo_count;
  logic [RW-1:0]        head;

  result_fifo #(.W(RW), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (result_val),
    .pop   (pop),
    .wdata (result_bus),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    assert (rst || (fifo_empty == (fifo_count == '0)));
  end

  assign result_rdy = ~rst & ~fifo_full;
  assign cfg_wr     = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_RESULT));
  assign fn_eff     = eff_frame(frame_nb);
  assign frame_end  = (res_cnt == fn_eff - 16'd1);

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    data_n  = str_data;
    val_n   = str_val;
    last_n  = str_last;
    wcnt_n  = wcnt;
    res_n   = res_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sreg_n  = head >> STR_WIDTH;
          data_n  = head[STR_WIDTH-1:0];
          wcnt_n  = '0;
          val_n   = 1'b1;
          last_n  = (WORDS == 1) && frame_end;
          state_n = SEND;
        end
      end
      SEND: begin
        if (str_val && str_rdy) begin
          if (wcnt != LAST_W) begin
            wcnt_n = WCW'(wcnt + 1'b1);
            data_n = sreg[STR_WIDTH-1:0];
            sreg_n = sreg >> STR_WIDTH;
            last_n = (wcnt_n == LAST_W) && frame_end;
          end else begin
            // Last word of a result accepted: advance the frame position,
            // then chain straight into the next entry if one is waiting.
            res_n = frame_end ? 16'd0 : res_cnt + 16'd1;
            if (!fifo_empty) begin
              pop    = 1'b1;
              sreg_n = head >> STR_WIDTH;
              data_n = head[STR_WIDTH-1:0];
              wcnt_n = '0;
              last_n = (WORDS == 1) && (res_n == fn_eff - 16'd1);
            end else begin
              val_n   = 1'b0;
              last_n  = 1'b0;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      str_data <= '0;
      str_val  <= 1'b0;
      str_last <= 1'b0;
      wcnt     <= '0;
      res_cnt  <= '0;
      frame_nb <= 16'd1;
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      str_data <= data_n;
      str_val  <= val_n;
      str_last <= last_n;
      wcnt     <= wcnt_n;
      if (cfg_wr) begin
        frame_nb <= cfg_data[15:0];
        res_cnt  <= '0;
      end else begin
        res_cnt  <= res_n;
      end
    end
  end

endmodule

// File: tb/tb_result_pack.sv
// Randomized self-checking bench for result_pack with a word-level scoreboard.
module tb_result_pack;
  import result_pack_pkg::*;

  localparam int DN = 4, IW = 16, SW = 32, AW = 2;
  localparam int RW = DN * IW, WORDS = RW / SW;

  logic          clk, rst;
  logic [31:0]   cfg_data;
  logic [4:0]    cfg_addr;
  logic          cfg_valid;
  logic [RW-1:0] result_bus;
  logic          result_val, result_rdy;
  logic [SW-1:0] str_data;
  logic          str_last, str_val, str_rdy;

  result_pack #(
    .CFG_DWIDTH(32), .CFG_AWIDTH(5), .DEPTH_NB(DN),
    .IMG_WIDTH(IW), .STR_WIDTH(SW), .FIFO_AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
    .cfg_valid(cfg_valid), .result_bus(result_bus), .result_val(result_val),
    .result_rdy(result_rdy), .str_data(str_data), .str_last(str_last),
    .str_val(str_val), .str_rdy(str_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [SW-1:0] d; logic l; } wexp_t;
  wexp_t q[$];
  int checks = 0, errors = 0, words_seen = 0;
  int fn = 1, mres = 0;

  // Reference: each accepted result becomes WORDS words, low word first;
  // the last word of the fn-th result in a frame carries the last flag.
  function automatic void model_accept(input logic [RW-1:0] d);
    wexp_t e;
    for (int k = 0; k < WORDS; k++) begin
      e.d = d[k*SW +: SW];
      e.l = (k == WORDS - 1) && (mres == fn - 1);
      q.push_back(e);
    end
    mres = (mres + 1) % fn;
  endfunction

  logic          pv, prd;
  logic [SW-1:0] pd;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0; prd = 1'b0; pd = '0;
    end else begin
      if (pv && !prd) begin
        checks++;
        if (str_val !== 1'b1 || str_data !== pd) begin
          errors++;
          $display("FAIL stall_hold: val=%b data=%h, required val=1 data=%h", str_val, str_data, pd);
        end
      end
      if (str_val === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_word: data=%h emitted, required none", str_data);
        end else if (str_rdy) begin
          wexp_t e;
          e = q.pop_front();
          checks++; words_seen++;
          if (str_data !== e.d || str_last !== e.l) begin
            errors++;
            $display("FAIL stream_word: data=%h last=%b, required data=%h last=%b", str_data, str_last, e.d, e.l);
          end
        end
      end
      if (result_val && result_rdy === 1'b1) model_accept(result_bus);
      pv = str_val; prd = str_rdy; pd = str_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [15:0] v);
    cfg_valid = 1'b1; cfg_addr = 5'(CFG_RESULT); cfg_data = {16'h0, v};
    tick();
    cfg_valid = 1'b0;
    fn = (v == 0) ? 1 : int'(v);
    mres = 0;
  endtask

  task automatic send(input logic [RW-1:0] d);
    bit ok = 0;
    result_val = 1'b1; result_bus = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (result_rdy === 1'b1) ok = 1;
      @(posedge clk); #1;
    end
    result_val = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: result %h never accepted, required acceptance", d);
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (q.size() == 0 && str_val === 1'b0) done = 1;
      else tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: %0d words still pending, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    result_val = 1'b0; result_bus = '0; str_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (str_val !== 1'b0 || str_last !== 1'b0 || str_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: val=%b last=%b data=%h, required 0 0 0", str_val, str_last, str_data);
    end
    checks++;
    if (result_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy: result_rdy=%b, required 0", result_rdy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (result_rdy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_rdy: result_rdy=%b, required 1", result_rdy);
    end
    tick();
  endtask

  task automatic test_basic();
    int w0;
    cfg_write(16'd2);
    str_rdy = 1'b1;
    w0 = words_seen;
    result_bus = 64'h4444_3333_2222_1111; result_val = 1'b1;
    @(negedge clk);
    checks++;
    if (result_rdy !== 1'b1) begin
      errors++; $display("FAIL basic_rdy: result_rdy=%b, required 1", result_rdy);
    end
    @(posedge clk); #1;
    result_val = 1'b0;
    @(negedge clk);
    checks++;
    if (str_val !== 1'b0) begin
      errors++; $display("FAIL latency_early: str_val=%b one cycle after accept, required 0", str_val);
    end
    @(negedge clk);
    checks++;
    if (str_val !== 1'b1 || str_data !== 32'h2222_1111 || str_last !== 1'b0) begin
      errors++;
      $display("FAIL latency_first: val=%b data=%h last=%b, required 1 22221111 0", str_val, str_data, str_last);
    end
    @(posedge clk); #1;
    wait_drain();
    send(64'hDDDD_CCCC_BBBB_AAAA);
    wait_drain();
    send({$urandom, $urandom});
    wait_drain();
    checks++;
    if (words_seen - w0 != 3 * WORDS) begin
      errors++; $display("FAIL basic_count: %0d words, required %0d", words_seen - w0, 3 * WORDS);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, run = 0;
    bit stop = 0, rdy_back = 0;
    cfg_write(16'd2);
    str_rdy = 1'b0; result_val = 1'b1;
    for (int i = 0; i < 20 && !stop; i++) begin
      result_bus = {$urandom, $urandom};
      @(negedge clk);
      if (result_rdy === 1'b1) acc++; else stop = 1;
      @(posedge clk); #1;
    end
    // One result sits in the serializer, the rest fill the FIFO.
    checks++;
    if (acc != (2 ** AW) + 1) begin
      errors++; $display("FAIL fill_count: %0d accepted, required %0d", acc, (2 ** AW) + 1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (result_rdy !== 1'b0) begin
        errors++; $display("FAIL full_hold: result_rdy=%b while full, required 0", result_rdy);
      end
      @(posedge clk); #1;
    end
    result_val = 1'b0;
    str_rdy = 1'b1;
    for (int i = 0; i < acc * WORDS; i++) begin
      @(negedge clk);
      if (str_val === 1'b1) run++;
      if (i == 2 && result_rdy === 1'b1) rdy_back = 1;
    end
    checks++;
    if (run != acc * WORDS) begin
      errors++; $display("FAIL no_bubble: %0d valid cycles, required %0d", run, acc * WORDS);
    end
    checks++;
    if (!rdy_back) begin
      errors++; $display("FAIL rdy_return: result_rdy low after first pop, required 1");
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_stall();
    cfg_write(16'd3);
    fork
      begin
        for (int i = 0; i < 40; i++) begin tick(); str_rdy = ~str_rdy; end
      end
      begin
        for (int r = 0; r < 3; r++) send({$urandom, $urandom});
      end
    join
    str_rdy = 1'b1;
    wait_drain();
  endtask

  task automatic test_frame_zero();
    cfg_write(16'd0);
    str_rdy = 1'b1;
    for (int r = 0; r < 3; r++) send({$urandom, $urandom});
    wait_drain();
  endtask

  task automatic test_random();
    cfg_write(16'($urandom_range(1, 3)));
    for (int i = 0; i < 300; i++) begin
      result_val = 1'($urandom % 2);
      result_bus = {$urandom, $urandom};
      str_rdy    = 1'($urandom % 2);
      tick();
    end
    result_val = 1'b0; str_rdy = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit quiet = 1;
    cfg_write(16'd2);
    str_rdy = 1'b0;
    for (int r = 0; r < 4; r++) send({$urandom, $urandom});
    str_rdy = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (str_val !== 1'b0 || str_last !== 1'b0 || result_rdy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: val=%b last=%b rdy=%b, required 0 0 0", str_val, str_last, result_rdy);
    end
    q.delete(); fn = 1; mres = 0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (str_val !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL stale_after_reset: str_val seen high, required 0");
    end
    checks++;
    if (result_rdy !== 1'b1) begin
      errors++; $display("FAIL rdy_after_reset: result_rdy=%b, required 1", result_rdy);
    end
    @(posedge clk); #1;
    send(64'h0123_4567_89AB_CDEF);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_frame_zero();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
